debug_mem_loader: RTL

Debug-side loader that sits directly upstream of the 2048x32 program memory wrapper. While a load session is active, it receives a byte stream from the debug link and assembles little-endian 32-bit words. It writes them into memory two words per write cycle, using both data inputs. It holds the CPU PC off the memory until the session completes, then hands the memory back for read-only fetch.

---
 rtl/debug_pkg.sv | 16 +
 rtl/debug_mem_loader_packer.sv | 39 +++
 rtl/debug_mem_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug-side program memory loader: FSM states,
// memory geometry and the default pad word.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FLUSH,
    DONE
  } state_t;

  localparam int          MEM_WORDS        = 2048;
  localparam logic [31:0] DEFAULT_PAD_WORD = 32'h0000_0000;

endpackage

// File: rtl/debug_mem_loader_packer.sv
// byte_word_packer: assembles a little-endian 32-bit word from a byte stream.
// word_next is the word including the byte presented this cycle.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic [1:0]  byte_idx,
  output logic        word_complete
);

  logic [31:0] acc;

  // Earlier bytes of the current word always sit below byte_idx, so stale
  // upper bytes in acc are overwritten before the word is ever complete.
  always_comb begin
    word_next = acc;
    word_next[{byte_idx, 3'b000} +: 8] = byte_data;
  end

  assign word_complete = byte_en && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= 2'd0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_en) begin
      acc <= word_next;
    end
  end

endmodule

// File: rtl/debug_mem_loader.sv
// Debug memory loader: packs a byte stream into word pairs and writes them to
// the program memory while a session is open. Optional LOADER_CHECKSUM_EN adds
// a running sum of every written word on the checksum output.
module debug_mem_loader
  import debug_pkg::*;
#(
  parameter int          MAX_WORDS = MEM_WORDS,
  parameter int          BASE_ADDR = 0,
  parameter logic [31:0] PAD_WORD  = DEFAULT_PAD_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        finish,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain1,
  output logic [31:0] mem_datain2,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic [11:0] word_count,
  output logic        overflow,
  output logic        misaligned
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [12:0] MAX_W = 13'(MAX_WORDS);
  localparam logic [31:0] BASE  = 32'(BASE_ADDR);

  state_t      state;
  logic        have_lo;
  logic [31:0] pair_lo;
  logic        finish_pend;

  logic        full;
  logic        take;
  logic        pair_done;
  logic [31:0] word_next;
  logic [1:0]  byte_idx;
  logic        word_complete;

  function automatic logic [11:0] sat_add(input logic [11:0] cnt, input logic [12:0] inc);
    logic [12:0] sum;
    sum = {1'b0, cnt} + inc;
    return (sum > MAX_W) ? MAX_W[11:0] : sum[11:0];
  endfunction

  assign full      = ({1'b0, word_count} >= MAX_W);
  assign take      = byte_valid && byte_ready && !full;
  assign pair_done = take && word_complete && have_lo;

  byte_word_packer u_packer (
    .clk          (Clk),
    .rst          (Rst),
    .clear        (state != COLLECT),
    .byte_en      (take),
    .byte_data    (byte_data),
    .word_next    (word_next),
    .byte_idx     (byte_idx),
    .word_complete(word_complete)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      byte_ready  <= 1'b0;
      mem_wr      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_address <= BASE;
      mem_datain1 <= '0;
      mem_datain2 <= '0;
      word_count  <= '0;
      overflow    <= 1'b0;
      misaligned  <= 1'b0;
      have_lo     <= 1'b0;
      finish_pend <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= COLLECT;
            busy        <= 1'b1;
            byte_ready  <= 1'b1;
            word_count  <= '0;
            overflow    <= 1'b0;
            misaligned  <= 1'b0;
            mem_address <= BASE;
            have_lo     <= 1'b0;
            finish_pend <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
          end
        end

        COLLECT: begin
          if (byte_valid && full) begin
            overflow <= 1'b1;
          end
          if (take && word_complete && !have_lo) begin
            have_lo <= 1'b1;
            pair_lo <= word_next;
          end
          // A completed pair wins over finish; finish is remembered for after WRITE.
          if (pair_done) begin
            have_lo     <= 1'b0;
            mem_datain1 <= pair_lo;
            mem_datain2 <= word_next;
            mem_wr      <= 1'b0;
            byte_ready  <= 1'b0;
            finish_pend <= finish;
            state       <= WRITE;
          end else if (finish) begin
            byte_ready <= 1'b0;
            have_lo    <= 1'b0;
            state      <= FLUSH;
            misaligned <= misaligned | (take ? (byte_idx != 2'd3) : (byte_idx != 2'd0));
            if (have_lo || (take && word_complete)) begin
              mem_wr      <= 1'b0;
              mem_datain1 <= have_lo ? pair_lo : word_next;
              mem_datain2 <= PAD_WORD;
            end
          end
        end

        WRITE: begin
          mem_wr      <= 1'b1;
          mem_address <= mem_address + 32'd2;
          word_count  <= sat_add(word_count, 13'd2);
`ifdef LOADER_CHECKSUM_EN
          checksum    <= checksum + mem_datain1 + mem_datain2;
`endif
          if (finish_pend || finish) begin
            finish_pend <= 1'b0;
            state       <= FLUSH;
          end else begin
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end

        FLUSH: begin
          if (!mem_wr) begin
            word_count <= sat_add(word_count, 13'd1);
`ifdef LOADER_CHECKSUM_EN
            checksum   <= checksum + mem_datain1 + mem_datain2;
`endif
          end
          mem_wr <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
